// File: rtl/bus_oe_sequencer.sv
// Break-before-make output-enable sequencer for a shared tri-state bus with N drivers.
// On every handover no driver is enabled for DEAD clock cycles; all outputs come straight from flops.
module bus_oe_sequencer #(
    parameter int N    = 4,
    parameter int DEAD = 1,
    parameter int SELW = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            en,
    input  logic [SELW-1:0] sel,
    output logic [N-1:0]    oe,
    output logic [SELW-1:0] active,
    output logic            busy
);

    localparam int CNT_W = $clog2(DEAD + 1);
    localparam logic [SELW:0] N_EXT = (SELW + 1)'(N);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEAD - 1);

    generate
        if (N < 2 || DEAD < 1) begin : g_param_err
            $error("bus_oe_sequencer: N must be >= 2 and DEAD must be >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t           state_q;
    logic [N-1:0]     oe_q;
    logic [SELW-1:0]  active_q;
    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;

    logic             req_vld;
    logic [N-1:0]     sel_oh_d;

    function automatic logic [N-1:0] decode(input logic [SELW-1:0] idx);
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (idx == SELW'(i)) v[i] = 1'b1;
        end
        return v;
    endfunction

    // An index at or beyond N means "no driver" and is treated exactly like en = 0.
    assign req_vld  = en && ({1'b0, sel} < N_EXT);
    assign sel_oh_d = decode(sel);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            oe_q     <= '0;
            active_q <= '0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_vld) begin
                        state_q  <= DRIVE;
                        active_q <= sel;
                        oe_q     <= sel_oh_d;
                    end
                end
                DRIVE: begin
                    if (!req_vld || sel != active_q) begin
                        state_q <= TURN;
                        oe_q    <= '0;
                        busy_q  <= 1'b1;
                        cnt_q   <= CNT_LOAD;
                    end
                end
                TURN: begin
                    // Requests are only looked at on the last dead cycle, so the gap is never shortened.
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (req_vld) begin
                        state_q  <= DRIVE;
                        active_q <= sel;
                        oe_q     <= sel_oh_d;
                        busy_q   <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    oe_q    <= '0;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign oe     = oe_q;
    assign active = active_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_bus_oe_sequencer.sv
// Self-checking bench for bus_oe_sequencer: directed table, multi-cycle corner sequences,
// and a random soak of three N=8 instances against a dead-time countdown model.
module tb_bus_oe_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // A: N=4 DEAD=2
    logic       a_rst = 1'b1, a_en = 1'b0;
    logic [1:0] a_sel = '0;
    logic [3:0] a_oe;
    logic [1:0] a_act;
    logic       a_busy;
    // B: N=4 DEAD=3
    logic       b_rst = 1'b1, b_en = 1'b0;
    logic [1:0] b_sel = '0;
    logic [3:0] b_oe;
    logic [1:0] b_act;
    logic       b_busy;
    // C: N=3 DEAD=1
    logic       c_rst = 1'b1, c_en = 1'b0;
    logic [1:0] c_sel = '0;
    logic [2:0] c_oe;
    logic [1:0] c_act;
    logic       c_busy;
    // D: N=4 DEAD=4
    logic       d_rst = 1'b1, d_en = 1'b0;
    logic [1:0] d_sel = '0;
    logic [3:0] d_oe;
    logic [1:0] d_act;
    logic       d_busy;
    // Soak: N=8, DEAD = 1, 2, 3 sharing one input stream
    logic       r_rst = 1'b1, r_en = 1'b0;
    logic [2:0] r_sel = '0;
    logic [7:0] r_oe  [3];
    logic [2:0] r_act [3];
    logic       r_busy[3];

    bus_oe_sequencer #(.N(4), .DEAD(2)) u_a (.clk(clk), .reset(a_rst), .en(a_en), .sel(a_sel),
        .oe(a_oe), .active(a_act), .busy(a_busy));
    bus_oe_sequencer #(.N(4), .DEAD(3)) u_b (.clk(clk), .reset(b_rst), .en(b_en), .sel(b_sel),
        .oe(b_oe), .active(b_act), .busy(b_busy));
    bus_oe_sequencer #(.N(3), .DEAD(1)) u_c (.clk(clk), .reset(c_rst), .en(c_en), .sel(c_sel),
        .oe(c_oe), .active(c_act), .busy(c_busy));
    bus_oe_sequencer #(.N(4), .DEAD(4)) u_d (.clk(clk), .reset(d_rst), .en(d_en), .sel(d_sel),
        .oe(d_oe), .active(d_act), .busy(d_busy));
    bus_oe_sequencer #(.N(8), .DEAD(1)) u_r1 (.clk(clk), .reset(r_rst), .en(r_en), .sel(r_sel),
        .oe(r_oe[0]), .active(r_act[0]), .busy(r_busy[0]));
    bus_oe_sequencer #(.N(8), .DEAD(2)) u_r2 (.clk(clk), .reset(r_rst), .en(r_en), .sel(r_sel),
        .oe(r_oe[1]), .active(r_act[1]), .busy(r_busy[1]));
    bus_oe_sequencer #(.N(8), .DEAD(3)) u_r3 (.clk(clk), .reset(r_rst), .en(r_en), .sel(r_sel),
        .oe(r_oe[2]), .active(r_act[2]), .busy(r_busy[2]));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] sel;
        logic [3:0] oe;
        logic [1:0] act;
        logic       busy;
    } vec_t;

    vec_t tbl[20];

    // Soak model: drv/own describe the granted channel, dl counts dead cycles still to be shown.
    bit drv[3];
    int own[3];
    int dl[3];
    int last_own[3];
    int zeros[3];

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 2'd2, 4'b0000, 2'd0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 2'd2, 4'b0000, 2'd0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 2'd2, 4'b0100, 2'd2, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 2'd1, 4'b0000, 2'd2, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 2'd1, 4'b0000, 2'd2, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 2'd1, 4'b0010, 2'd1, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 2'd3, 4'b0000, 2'd1, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 2'd3, 4'b0000, 2'd1, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 2'd3, 4'b1000, 2'd3, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 2'd3, 4'b0000, 2'd3, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 2'd3, 4'b0000, 2'd3, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 2'd3, 4'b0000, 2'd3, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 2'd0, 4'b0000, 2'd3, 1'b0};
        tbl[13] = '{1'b0, 1'b1, 2'd0, 4'b0001, 2'd0, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 2'd0, 4'b0000, 2'd0, 1'b1};
        tbl[15] = '{1'b0, 1'b1, 2'd0, 4'b0000, 2'd0, 1'b1};
        tbl[16] = '{1'b0, 1'b1, 2'd0, 4'b0001, 2'd0, 1'b0};
        tbl[17] = '{1'b0, 1'b1, 2'd2, 4'b0000, 2'd0, 1'b1};
        tbl[18] = '{1'b0, 1'b1, 2'd1, 4'b0000, 2'd0, 1'b1};
        tbl[19] = '{1'b0, 1'b0, 2'd1, 4'b0000, 2'd0, 1'b0};

        // Table-driven run on A
        for (int i = 0; i < 20; i++) begin
            a_rst = tbl[i].rst;
            a_en  = tbl[i].en;
            a_sel = tbl[i].sel;
            tick();
            chk($sformatf("tblA[%0d].oe", i),     32'(a_oe),   32'(tbl[i].oe));
            chk($sformatf("tblA[%0d].active", i), 32'(a_act),  32'(tbl[i].act));
            chk($sformatf("tblA[%0d].busy", i),   32'(a_busy), 32'(tbl[i].busy));
        end

        // Bounce-back on B: dead time is served in full even though sel returns to the owner
        b_rst = 1'b1; b_en = 1'b1; b_sel = 2'd0;
        tick();
        b_rst = 1'b0;
        tick();
        chk("bounce.grant0", 32'(b_oe), 32'b0001);
        b_sel = 2'd2;
        tick();
        chk("bounce.dead1.oe", 32'(b_oe), 32'b0000);
        chk("bounce.dead1.busy", 32'(b_busy), 32'd1);
        b_sel = 2'd0;
        tick();
        chk("bounce.dead2.oe", 32'(b_oe), 32'b0000);
        tick();
        chk("bounce.dead3.oe", 32'(b_oe), 32'b0000);
        chk("bounce.dead3.busy", 32'(b_busy), 32'd1);
        tick();
        chk("bounce.regrant.oe", 32'(b_oe), 32'b0001);
        chk("bounce.regrant.busy", 32'(b_busy), 32'd0);

        // Out-of-range select on C (N=3): sel=3 behaves as no request
        c_rst = 1'b1; c_en = 1'b1; c_sel = 2'd3;
        tick();
        c_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("oor[%0d].oe", i),   32'(c_oe),   32'd0);
            chk($sformatf("oor[%0d].busy", i), 32'(c_busy), 32'd0);
        end
        c_sel = 2'd1;
        tick();
        chk("oor.valid.oe", 32'(c_oe), 32'b010);
        chk("oor.valid.active", 32'(c_act), 32'd1);
        c_sel = 2'd3;
        tick();
        chk("oor.release.oe", 32'(c_oe), 32'd0);
        chk("oor.release.busy", 32'(c_busy), 32'd1);

        // Reset mid-TURN on D (DEAD=4)
        d_rst = 1'b1; d_en = 1'b1; d_sel = 2'd1;
        tick();
        d_rst = 1'b0;
        tick();
        chk("midturn.grant", 32'(d_oe), 32'b0010);
        d_sel = 2'd2;
        tick();
        chk("midturn.turn1.busy", 32'(d_busy), 32'd1);
        tick();
        chk("midturn.turn2.busy", 32'(d_busy), 32'd1);
        d_rst = 1'b1;
        tick();
        chk("midturn.rst.oe", 32'(d_oe), 32'd0);
        chk("midturn.rst.busy", 32'(d_busy), 32'd0);
        chk("midturn.rst.active", 32'(d_act), 32'd0);
        d_rst = 1'b0;
        tick();
        chk("midturn.after.oe", 32'(d_oe), 32'b0100);
        chk("midturn.after.active", 32'(d_act), 32'd2);

        // Random soak
        for (int k = 0; k < 3; k++) begin
            drv[k] = 1'b0; own[k] = 0; dl[k] = 0; last_own[k] = -1; zeros[k] = 0;
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            r_rst = (cyc < 2) || ($urandom_range(0, 127) == 0);
            r_en  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) r_sel = 3'($urandom_range(0, 7));
            tick();
            for (int k = 0; k < 3; k++) begin
                int dead;
                int idx;
                logic [7:0] exp_oe;
                dead = k + 1;
                if (r_rst) begin
                    drv[k] = 1'b0; own[k] = 0; dl[k] = 0;
                end else if (drv[k]) begin
                    if (!r_en || int'(r_sel) != own[k]) begin
                        drv[k] = 1'b0;
                        dl[k]  = dead;
                    end
                end else if (dl[k] > 0) begin
                    dl[k]--;
                    if (dl[k] == 0 && r_en) begin
                        drv[k] = 1'b1; own[k] = int'(r_sel);
                    end
                end else if (r_en) begin
                    drv[k] = 1'b1; own[k] = int'(r_sel);
                end
                exp_oe = drv[k] ? (8'd1 << own[k]) : 8'd0;
                chk($sformatf("soak%0d[%0d].oe", dead, cyc),     32'(r_oe[k]),   32'(exp_oe));
                chk($sformatf("soak%0d[%0d].active", dead, cyc), 32'(r_act[k]),  32'(own[k]));
                chk($sformatf("soak%0d[%0d].busy", dead, cyc),   32'(r_busy[k]), 32'(dl[k] > 0));
                chk($sformatf("soak%0d[%0d].onehot0", dead, cyc), 32'($onehot0(r_oe[k])), 32'd1);
                if (r_rst) begin
                    last_own[k] = -1; zeros[k] = 0;
                end else if (r_oe[k] == 8'd0) begin
                    zeros[k]++;
                end else begin
                    idx = 0;
                    for (int j = 0; j < 8; j++) if (r_oe[k][j]) idx = j;
                    if (last_own[k] >= 0 && idx != last_own[k])
                        chk($sformatf("soak%0d[%0d].gap(%0d)", dead, cyc, zeros[k]),
                            32'(zeros[k] >= dead), 32'd1);
                    last_own[k] = idx;
                    zeros[k] = 0;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
